// File: rtl/grf_wb_arbiter_if.sv
// rtl/grf_wb_arbiter_if.sv - GRF write-port arbitration bus: WB, MDU, hazard and GRF signals
interface grf_wb_arbiter_if;
   logic        WBWrite;
   logic [4:0]  WBAddr;
   logic [31:0] WBData;
   logic        MDUValid;
   logic [4:0]  MDUAddr;
   logic [31:0] MDUData;
   logic        MDUReady;
   logic [4:0]  HazAddrA;
   logic [4:0]  HazAddrB;
   logic        HazA;
   logic        HazB;
   logic        StallWB;
   logic        RegWrite;
   logic [4:0]  RegAddr;
   logic [31:0] RegData;

   modport slave (
      input  WBWrite, WBAddr, WBData, MDUValid, MDUAddr, MDUData, HazAddrA, HazAddrB,
      output MDUReady, HazA, HazB, StallWB, RegWrite, RegAddr, RegData
   );

   modport master (
      output WBWrite, WBAddr, WBData, MDUValid, MDUAddr, MDUData, HazAddrA, HazAddrB,
      input  MDUReady, HazA, HazB, StallWB, RegWrite, RegAddr, RegData
   );
endinterface

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter: WB priority, MDU result FIFO, forced drain
// Optional same-cycle MDU bypass enabled by GRF_WB_ARB_BYPASS_EN.
module grf_wb_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   grf_wb_arbiter_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {S_PIPE, S_FORCE} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              starve_q, starve_d;
   logic [CW-1:0]           count_q, count_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH-1:0]   live_q, live_d;
   logic [4:0]              addr_q [FIFO_DEPTH];
   logic [31:0]             data_q [FIFO_DEPTH];

   logic full, accept, any_live, head_live, head_valid, bypass, push;
   logic wb_grant, head_grant, pop;

   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign accept     = bus.MDUValid && !full;
   assign any_live   = |live_q;
   // Popping clears the live bit, so a set bit always denotes an occupied slot.
   assign head_live  = live_q[rd_ptr_q];
   assign head_valid = (count_q != '0);

`ifdef GRF_WB_ARB_BYPASS_EN
   assign bypass = accept && !any_live && !bus.WBWrite && (state_q == S_PIPE)
                   && (bus.MDUAddr != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   // Results for r0 are acknowledged but never occupy a slot.
   assign push = accept && (bus.MDUAddr != 5'd0) && !bypass;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_PIPE;
         starve_q <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         live_q   <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         live_q   <= live_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= bus.MDUAddr;
         data_q[wr_ptr_q] <= bus.MDUData;
      end
   end

   always_comb begin
      wb_grant     = 1'b0;
      head_grant   = 1'b0;
      pop          = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RegAddr  = 5'd0;
      bus.RegData  = 32'd0;
      bus.HazA     = 1'b0;
      bus.HazB     = 1'b0;
      case (state_q)
         S_PIPE: begin
            if (bus.WBWrite) wb_grant = 1'b1;
            else if (head_live) head_grant = 1'b1;
            pop = head_valid && (head_grant || !head_live);
         end
         S_FORCE: begin
            head_grant = head_live;
            pop        = head_valid;
         end
         default: ;
      endcase
      bus.RegWrite = wb_grant || head_grant || bypass;
      if (wb_grant) begin
         bus.RegAddr = bus.WBAddr;
         bus.RegData = bus.WBData;
      end else if (head_grant) begin
         bus.RegAddr = addr_q[rd_ptr_q];
         bus.RegData = data_q[rd_ptr_q];
      end else if (bypass) begin
         bus.RegAddr = bus.MDUAddr;
         bus.RegData = bus.MDUData;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (live_q[i] && addr_q[i] == bus.HazAddrA) bus.HazA = 1'b1;
         if (live_q[i] && addr_q[i] == bus.HazAddrB) bus.HazB = 1'b1;
      end
      if (accept && bus.MDUAddr == bus.HazAddrA) bus.HazA = 1'b1;
      if (accept && bus.MDUAddr == bus.HazAddrB) bus.HazB = 1'b1;
      if (bus.HazAddrA == 5'd0) bus.HazA = 1'b0;
      if (bus.HazAddrB == 5'd0) bus.HazB = 1'b0;
      bus.StallWB  = (state_q == S_FORCE);
      bus.MDUReady = !full;
   end

   always_comb begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

      // Kill before push so an entry written this edge survives a same-address WB write.
      live_d = live_q;
      if (wb_grant) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (addr_q[i] == bus.WBAddr) live_d[i] = 1'b0;
         end
      end
      if (pop)  live_d[rd_ptr_q] = 1'b0;
      if (push) live_d[wr_ptr_q] = 1'b1;

      starve_d = starve_q;
      state_d  = state_q;
      case (state_q)
         S_PIPE: begin
            if (head_grant || count_d == '0) starve_d = '0;
            else if (head_live) starve_d = starve_q + 4'd1;
            if (starve_d == 4'(STARVE_LIMIT)) state_d = S_FORCE;
         end
         S_FORCE: begin
            starve_d = '0;
            state_d  = S_PIPE;
         end
         default: begin
            starve_d = '0;
            state_d  = S_PIPE;
         end
      endcase
   end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed self-checking bench for grf_wb_arbiter
module tb_grf_wb_arbiter;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

`ifdef GRF_WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   grf_wb_arbiter_if bus ();

   grf_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic drive(input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
      bus.WBWrite  = wbw;
      bus.WBAddr   = wba;
      bus.WBData   = wbd;
      bus.MDUValid = mv;
      bus.MDUAddr  = ma;
      bus.MDUData  = md;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(0, 0, 0, 0, 0, 0);
      bus.HazAddrA = 5'd3;
      bus.HazAddrB = 5'd0;
      #12;
      checks++; if (bus.MDUReady !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.MDUReady); end
      checks++; if (bus.StallWB !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", bus.StallWB); end
      checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b expected 0", bus.RegWrite); end
      checks++; if (bus.HazA !== 1'b0) begin errors++; $display("FAIL rst_haza: got %b expected 0", bus.HazA); end
      @(negedge clk);
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_priority;
      drive(1, 5, 32'h11, 1, 6, 32'h22);
      bus.HazAddrB = 5'd6;
      #4;
      checks++; if (bus.RegWrite !== 1'b1 || bus.RegAddr !== 5'd5 || bus.RegData !== 32'h11) begin
         errors++; $display("FAIL prio_wb: got we=%b addr=%0d data=%h expected we=1 addr=5 data=11", bus.RegWrite, bus.RegAddr, bus.RegData); end
      checks++; if (bus.HazB !== 1'b1) begin errors++; $display("FAIL prio_hazb_push: got %b expected 1", bus.HazB); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      bus.HazAddrB = 5'd0;
      #4;
      checks++; if (bus.RegWrite !== 1'b1 || bus.RegAddr !== 5'd6 || bus.RegData !== 32'h22) begin
         errors++; $display("FAIL prio_mdu: got we=%b addr=%0d data=%h expected we=1 addr=6 data=22", bus.RegWrite, bus.RegAddr, bus.RegData); end
      next_cycle();
      #4;
      checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b expected 0", bus.RegWrite); end
      next_cycle();
   endtask

   task automatic test_starvation;
      drive(1, 10, 32'hA0A0, 1, 3, 32'h33);
      next_cycle();
      for (int i = 1; i <= 5; i++) begin
         drive(1, 10, 32'hA0A0, 0, 0, 0);
         #4;
         checks++; if (bus.StallWB !== (i == 4)) begin
            errors++; $display("FAIL starve_stall c%0d: got %b expected %b", i, bus.StallWB, (i == 4)); end
         checks++; if (bus.RegAddr !== ((i == 4) ? 5'd3 : 5'd10)) begin
            errors++; $display("FAIL starve_addr c%0d: got %0d expected %0d", i, bus.RegAddr, (i == 4) ? 3 : 10); end
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_full;
      logic [4:0] exp_addr [5];
      exp_addr[0] = 5'd12; exp_addr[1] = 5'd13; exp_addr[2] = 5'd14;
      exp_addr[3] = 5'd16; exp_addr[4] = 5'd0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 20, 32'h2020, 1, 5'(11 + i), 32'h1000 + 32'(11 + i));
         #4;
         checks++; if (bus.MDUReady !== 1'b1) begin errors++; $display("FAIL full_ready_fill%0d: got %b expected 1", i, bus.MDUReady); end
         next_cycle();
      end
      drive(1, 20, 32'h2020, 1, 15, 32'h1015);
      bus.HazAddrA = 5'd15;
      #4;
      checks++; if (bus.MDUReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.MDUReady); end
      checks++; if (bus.StallWB !== 1'b1 || bus.RegAddr !== 5'd11) begin
         errors++; $display("FAIL full_force: got stall=%b addr=%0d expected stall=1 addr=11", bus.StallWB, bus.RegAddr); end
      checks++; if (bus.HazA !== 1'b0) begin errors++; $display("FAIL full_drop_haz: got %b expected 0", bus.HazA); end
      next_cycle();
      drive(0, 0, 0, 1, 16, 32'h1016);
      bus.HazAddrA = 5'd0;
      #4;
      checks++; if (bus.MDUReady !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b expected 1", bus.MDUReady); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            drive(0, 0, 0, 0, 0, 0);
            #4;
         end
         if (i == 1) begin
            checks++; if (bus.MDUReady !== 1'b1) begin errors++; $display("FAIL full_pushpop_count: got ready=%b expected 1", bus.MDUReady); end
         end
         checks++; if (bus.RegWrite !== (i < 4) || bus.RegAddr !== exp_addr[i]) begin
            errors++; $display("FAIL full_order%0d: got we=%b addr=%0d expected we=%b addr=%0d", i, bus.RegWrite, bus.RegAddr, (i < 4), exp_addr[i]); end
         next_cycle();
      end
   endtask

   task automatic test_waw;
      drive(1, 1, 32'h1, 1, 7, 32'h777);
      next_cycle();
      drive(1, 7, 32'hAAAA, 0, 0, 0);
      bus.HazAddrA = 5'd7;
      #4;
      checks++; if (bus.HazA !== 1'b1) begin errors++; $display("FAIL waw_haz_before: got %b expected 1", bus.HazA); end
      checks++; if (bus.RegAddr !== 5'd7 || bus.RegData !== 32'hAAAA) begin
         errors++; $display("FAIL waw_wb: got addr=%0d data=%h expected addr=7 data=aaaa", bus.RegAddr, bus.RegData); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #4;
         checks++; if (bus.HazA !== 1'b0 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL waw_killed c%0d: got haz=%b we=%b expected haz=0 we=0", i, bus.HazA, bus.RegWrite); end
         next_cycle();
      end
      drive(1, 8, 32'h8, 1, 8, 32'h888);
      bus.HazAddrA = 5'd8;
      #4;
      checks++; if (bus.HazA !== 1'b1) begin errors++; $display("FAIL waw_push_haz: got %b expected 1", bus.HazA); end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      #4;
      checks++; if (bus.HazA !== 1'b1 || bus.RegWrite !== 1'b1 || bus.RegData !== 32'h888) begin
         errors++; $display("FAIL waw_same_cycle_survives: got haz=%b we=%b data=%h expected haz=1 we=1 data=888", bus.HazA, bus.RegWrite, bus.RegData); end
      bus.HazAddrA = 5'd0;
      next_cycle();
   endtask

   task automatic test_bypass;
      int exp_cycle;
      exp_cycle = BYP ? 0 : 1;
      drive(0, 0, 0, 1, 9, 32'hABCD);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) drive(0, 0, 0, 0, 0, 0);
         #4;
         checks++; if (bus.RegWrite !== (c == exp_cycle)) begin
            errors++; $display("FAIL bypass_we c%0d: got %b expected %b", c, bus.RegWrite, (c == exp_cycle)); end
         if (c == exp_cycle) begin
            checks++; if (bus.RegAddr !== 5'd9 || bus.RegData !== 32'hABCD) begin
               errors++; $display("FAIL bypass_data: got addr=%0d data=%h expected addr=9 data=abcd", bus.RegAddr, bus.RegData); end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) begin
         drive(1, 21, 32'h2121, 1, 5'(24 + i), 32'h2400 + 32'(i));
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0);
      bus.HazAddrA = 5'd25;
      #2;
      checks++; if (bus.RegWrite !== 1'b1 || bus.RegAddr !== 5'd24) begin
         errors++; $display("FAIL rmid_drain: got we=%b addr=%0d expected we=1 addr=24", bus.RegWrite, bus.RegAddr); end
      reset = 1'b0;
      #1;
      checks++; if (bus.MDUReady !== 1'b1 || bus.StallWB !== 1'b0 || bus.RegWrite !== 1'b0 || bus.HazA !== 1'b0) begin
         errors++; $display("FAIL rmid_reset: got ready=%b stall=%b we=%b haz=%b expected 1 0 0 0", bus.MDUReady, bus.StallWB, bus.RegWrite, bus.HazA); end
      @(negedge clk);
      reset = 1'b1;
      next_cycle();
      #4;
      checks++; if (bus.RegWrite !== 1'b0 || bus.HazA !== 1'b0 || bus.MDUReady !== 1'b1) begin
         errors++; $display("FAIL rmid_after: got we=%b haz=%b ready=%b expected 0 0 1", bus.RegWrite, bus.HazA, bus.MDUReady); end
      bus.HazAddrA = 5'd0;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_starvation();
      test_full();
      test_waw();
      test_bypass();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
